// File: rtl/ws2812_frame_ctrl.sv
`default_nettype none
// ============================================================================
// ws2812_frame_ctrl : double-buffered pixel store and frame sequencer that
// feeds a WS2812 serializer one GRB pixel per read request.  Rev 1.0
// ============================================================================
module ws2812_frame_ctrl #(
  parameter int MAX_LEDS = 256,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [23:0]   wr_data,
  input  logic          commit,
  output logic          commit_ack,
  input  logic          cfg_load,
  input  logic [15:0]   num_leds_cfg,
  input  logic [15:0]   delay_cfg,
  input  logic          enable,
  input  logic          read_en,
  output logic [23:0]   rgb_data_out,
  output logic          data_dv,
  output logic          write_config,
  output logic [15:0]   num_leds_out,
  output logic [15:0]   delay_out,
  output logic          busy,
  output logic          frame_done,
  output logic [15:0]   frame_cnt
);

  localparam logic [15:0] c_MAX_LEDS16  = 16'(MAX_LEDS);
  localparam logic [15:0] c_RST_NUMLEDS = 16'd10;
  localparam logic [15:0] c_RST_DELAY   = 16'd15000;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CFG     = 3'd1,
    ARM     = 3'd2,
    SERVE   = 3'd3,
    FETCH   = 3'd4,
    PRESENT = 3'd5,
    WAITLOW = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t        state_q;
  logic          front_sel_q;
  logic [AW-1:0] pix_idx_q;
  logic          cfg_pend_q;
  logic [15:0]   pend_num_q;
  logic [15:0]   pend_delay_q;
  logic          commit_pend_q;
  logic [23:0]   rd_data_q;
  logic [23:0]   rgb_data_out_q;
  logic          data_dv_q;
  logic          write_config_q;
  logic          commit_ack_q;
  logic          frame_done_q;
  logic          busy_q;
  logic [15:0]   frame_cnt_q;
  logic [15:0]   num_leds_out_q;
  logic [15:0]   delay_out_q;

  logic [23:0]   buf0_q [MAX_LEDS];
  logic [23:0]   buf1_q [MAX_LEDS];

  logic          w_wr_ok;
  logic          w_rd_issue;
  logic          w_last_pix;
  logic [15:0]   w_num_clamped;

  assign w_wr_ok       = wr_en && (32'(wr_addr) < MAX_LEDS);
  assign w_rd_issue    = (state_q == SERVE) && read_en;
  assign w_last_pix    = (16'(pix_idx_q) == (num_leds_out_q - 16'd1));
  assign w_num_clamped = (num_leds_cfg > c_MAX_LEDS16) ? c_MAX_LEDS16 : num_leds_cfg;

  // Host writes always land in the buffer the serializer is not reading.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      if (front_sel_q) buf0_q[wr_addr] <= wr_data;
      else             buf1_q[wr_addr] <= wr_data;
    end
    if (w_rd_issue) rd_data_q <= front_sel_q ? buf1_q[pix_idx_q] : buf0_q[pix_idx_q];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      front_sel_q    <= 1'b0;
      pix_idx_q      <= '0;
      cfg_pend_q     <= 1'b0;
      pend_num_q     <= c_RST_NUMLEDS;
      pend_delay_q   <= c_RST_DELAY;
      commit_pend_q  <= 1'b0;
      rgb_data_out_q <= 24'd0;
      data_dv_q      <= 1'b0;
      write_config_q <= 1'b0;
      commit_ack_q   <= 1'b0;
      frame_done_q   <= 1'b0;
      busy_q         <= 1'b0;
      frame_cnt_q    <= 16'd0;
      num_leds_out_q <= c_RST_NUMLEDS;
      delay_out_q    <= c_RST_DELAY;
    end else begin
      write_config_q <= 1'b0;
      commit_ack_q   <= 1'b0;
      frame_done_q   <= 1'b0;
      data_dv_q      <= 1'b0;

      if (cfg_load) begin
        cfg_pend_q   <= 1'b1;
        pend_num_q   <= w_num_clamped;
        pend_delay_q <= delay_cfg;
      end
      if (commit) commit_pend_q <= 1'b1;

      case (state_q)
        IDLE: begin
          // Config strobe and new values are presented together while in CFG.
          if (cfg_pend_q) begin
            state_q        <= CFG;
            busy_q         <= 1'b1;
            write_config_q <= 1'b1;
            num_leds_out_q <= pend_num_q;
            delay_out_q    <= pend_delay_q;
            if (!cfg_load) cfg_pend_q <= 1'b0;
          end else if (enable && (num_leds_out_q != 16'd0)) begin
            state_q <= ARM;
            busy_q  <= 1'b1;
          end
        end
        CFG: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        ARM: begin
          pix_idx_q <= '0;
          if (commit_pend_q) begin
            front_sel_q  <= ~front_sel_q;
            commit_ack_q <= 1'b1;
            if (!commit) commit_pend_q <= 1'b0;
          end
          state_q <= SERVE;
        end
        SERVE: begin
          if (read_en) state_q <= FETCH;
        end
        FETCH: begin
          rgb_data_out_q <= rd_data_q;
          data_dv_q      <= 1'b1;
          state_q        <= PRESENT;
        end
        PRESENT: begin
          if (w_last_pix) begin
            state_q      <= DONE;
            frame_done_q <= 1'b1;
            frame_cnt_q  <= frame_cnt_q + 16'd1;
          end else begin
            pix_idx_q <= pix_idx_q + 1'b1;
            state_q   <= WAITLOW;
          end
        end
        WAITLOW: begin
          if (!read_en) state_q <= SERVE;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign commit_ack   = commit_ack_q;
  assign rgb_data_out = rgb_data_out_q;
  assign data_dv      = data_dv_q;
  assign write_config = write_config_q;
  assign num_leds_out = num_leds_out_q;
  assign delay_out    = delay_out_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign frame_cnt    = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_frame_ctrl.sv
`default_nettype none
// tb_ws2812_frame_ctrl : scoreboard bench with a simple serializer model.
module tb_ws2812_frame_ctrl;

  localparam int MAXL  = 256;
  localparam int CLK_P = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic        commit = 1'b0;
  logic        cfg_load = 1'b0;
  logic [15:0] num_leds_cfg = '0;
  logic [15:0] delay_cfg = '0;
  logic        enable = 1'b0;
  logic        read_en = 1'b0;
  logic        commit_ack;
  logic [23:0] rgb_data_out;
  logic        data_dv;
  logic        write_config;
  logic [15:0] num_leds_out;
  logic [15:0] delay_out;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_cnt;

  int          checks = 0;
  int          failures = 0;
  logic [23:0] exp_q [$];
  logic [23:0] bmodel [2][MAXL];
  bit          bfront = 1'b0;
  int          exp_fcnt = 0;
  int          mon_wc = 0, mon_ack = 0, mon_dv = 0, mon_fd = 0;
  logic [15:0] wc_num = '0, wc_delay = '0;
  time         t_ack = 0, t_dv = 0;

  ws2812_frame_ctrl #(.MAX_LEDS(256), .AW(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .commit_ack(commit_ack), .cfg_load(cfg_load),
    .num_leds_cfg(num_leds_cfg), .delay_cfg(delay_cfg), .enable(enable),
    .read_en(read_en), .rgb_data_out(rgb_data_out), .data_dv(data_dv),
    .write_config(write_config), .num_leds_out(num_leds_out), .delay_out(delay_out),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  always #(CLK_P/2) clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (write_config === 1'b1) begin mon_wc++; wc_num = num_leds_out; wc_delay = delay_out; end
    if (commit_ack === 1'b1) begin mon_ack++; t_ack = $time; end
    if (data_dv === 1'b1) begin mon_dv++; if (t_dv == 0) t_dv = $time; end
    if (frame_done === 1'b1) mon_fd++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wr_pixel(input int a, input logic [23:0] d);
    wr_en = 1'b1; wr_addr = 8'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
    bmodel[!bfront][a] = d;
  endtask

  task automatic do_cfg(input logic [15:0] n, input logic [15:0] d);
    int k;
    int wc0;
    wc0 = mon_wc;
    cfg_load = 1'b1; num_leds_cfg = n; delay_cfg = d;
    tick();
    cfg_load = 1'b0;
    k = 0;
    while (mon_wc == wc0 && k < 10) begin tick(); k++; end
    checks++;
    if (mon_wc != wc0 + 1) begin failures++; $display("FAIL cfg_write_config_count got=%0d want=%0d", mon_wc - wc0, 1); end
    repeat (2) tick();
  endtask

  // Serve one whole frame as the serializer would, checking every pixel.
  task automatic run_frame(input int n, input bit exp_swap, input bit chk_rgb,
                           input bit hold_first, input bit mid_cfg);
    int k, dv0, dvf0, ack0, fd0;
    logic [23:0] exp_v;
    ack0 = mon_ack; fd0 = mon_fd; dvf0 = mon_dv;
    t_dv = 0; t_ack = 0;
    if (exp_swap) bfront = !bfront;
    if (chk_rgb) for (int i = 0; i < n; i++) exp_q.push_back(bmodel[bfront][i]);
    enable = 1'b1;
    k = 0;
    while (busy !== 1'b1 && k < 20) begin tick(); k++; end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL frame_start busy=%b want=1", busy); end
    enable = 1'b0;
    tick();
    for (int p = 0; p < n; p++) begin
      dv0 = mon_dv;
      read_en = 1'b1;
      k = 0;
      do begin tick(); k++; end while (data_dv !== 1'b1 && k < 10);
      checks++;
      if (k != 2) begin failures++; $display("FAIL dv_latency pix=%0d got=%0d want=2", p, k); end
      if (chk_rgb) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rgb_scoreboard_empty pix=%0d got=%h", p, rgb_data_out);
        end else begin
          exp_v = exp_q.pop_front();
          if (rgb_data_out !== exp_v) begin failures++; $display("FAIL rgb pix=%0d got=%h want=%h", p, rgb_data_out, exp_v); end
        end
      end
      if (hold_first && p == 0) begin
        repeat (20) tick();
        checks++;
        if (mon_dv - dv0 != 1) begin failures++; $display("FAIL hold_dv_count got=%0d want=1", mon_dv - dv0); end
      end
      if (mid_cfg && p == 0) begin
        cfg_load = 1'b1; num_leds_cfg = 16'd5; delay_cfg = 16'd700; commit = 1'b1;
        tick();
        cfg_load = 1'b0; commit = 1'b0;
      end
      read_en = 1'b0;
      if (p < n - 1) repeat (3) tick();
    end
    k = 0;
    while (mon_fd == fd0 && k < 10) begin tick(); k++; end
    tick();
    exp_fcnt++;
    checks++;
    if (mon_fd - fd0 != 1) begin failures++; $display("FAIL frame_done_count got=%0d want=1", mon_fd - fd0); end
    checks++;
    if (mon_dv - dvf0 != n) begin failures++; $display("FAIL frame_dv_count got=%0d want=%0d", mon_dv - dvf0, n); end
    checks++;
    if (frame_cnt !== 16'(exp_fcnt)) begin failures++; $display("FAIL frame_cnt got=%0d want=%0d", frame_cnt, exp_fcnt); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_after_frame got=%b want=0", busy); end
    checks++;
    if (mon_ack - ack0 != int'(exp_swap)) begin failures++; $display("FAIL commit_ack_count got=%0d want=%0d", mon_ack - ack0, exp_swap); end
    if (exp_swap) begin
      checks++;
      if (!(t_ack != 0 && t_ack < t_dv)) begin failures++; $display("FAIL ack_order ack_t=%0t dv_t=%0t want ack first", t_ack, t_dv); end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({data_dv, write_config, commit_ack, frame_done, busy} !== 5'b0) begin
      failures++; $display("FAIL reset_strobes got=%b want=00000", {data_dv, write_config, commit_ack, frame_done, busy});
    end
    checks++;
    if (rgb_data_out !== 24'd0) begin failures++; $display("FAIL reset_rgb got=%h want=000000", rgb_data_out); end
    checks++;
    if (frame_cnt !== 16'd0) begin failures++; $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); end
    checks++;
    if (num_leds_out !== 16'd10 || delay_out !== 16'd15000) begin
      failures++; $display("FAIL reset_cfg got=%0d/%0d want=10/15000", num_leds_out, delay_out);
    end
    rst = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_cfg_frame();
    do_cfg(16'd3, 16'd500);
    checks++;
    if (wc_num !== 16'd3 || wc_delay !== 16'd500) begin failures++; $display("FAIL cfg_values got=%0d/%0d want=3/500", wc_num, wc_delay); end
    run_frame(3, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_pixels_commit();
    wr_pixel(0, 24'h0000FF);
    wr_pixel(1, 24'h00FF00);
    wr_pixel(2, 24'hFF0000);
    commit = 1'b1; tick(); commit = 1'b0;
    tick();
    commit = 1'b1; tick(); commit = 1'b0;
    run_frame(3, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_hold();
    wr_pixel(0, 24'h123456);
    wr_pixel(1, 24'hABCDEF);
    wr_pixel(2, 24'h0F0F0F);
    commit = 1'b1; tick(); commit = 1'b0;
    run_frame(3, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_midframe();
    int wc0, k;
    for (int i = 0; i < 5; i++) wr_pixel(i, 24'h101010 * 24'(i + 1) + 24'h000003);
    wc0 = mon_wc;
    run_frame(3, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (mon_wc != wc0) begin failures++; $display("FAIL midframe_no_cfg got=%0d want=0", mon_wc - wc0); end
    k = 0;
    while (mon_wc == wc0 && k < 10) begin tick(); k++; end
    checks++;
    if (mon_wc != wc0 + 1 || wc_num !== 16'd5 || wc_delay !== 16'd700) begin
      failures++; $display("FAIL deferred_cfg count=%0d num=%0d delay=%0d want=1/5/700", mon_wc - wc0, wc_num, wc_delay);
    end
    repeat (3) tick();
    run_frame(5, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_clamp_zero();
    int bad;
    do_cfg(16'd1000, 16'd200);
    checks++;
    if (num_leds_out !== 16'd256) begin failures++; $display("FAIL clamp num_leds_out got=%0d want=256", num_leds_out); end
    do_cfg(16'd0, 16'd200);
    enable = 1'b1;
    bad = 0;
    repeat (10) begin tick(); if (busy !== 1'b0) bad++; end
    enable = 1'b0;
    checks++;
    if (bad != 0) begin failures++; $display("FAIL zero_leds_busy got=%0d busy cycles want=0", bad); end
    do_cfg(16'd3, 16'd500);
  endtask

  task automatic test_rst_midframe();
    int k, dv0;
    logic [23:0] exp_v;
    exp_q.push_back(bmodel[bfront][0]);
    enable = 1'b1;
    k = 0;
    while (busy !== 1'b1 && k < 20) begin tick(); k++; end
    enable = 1'b0;
    tick();
    read_en = 1'b1;
    k = 0;
    do begin tick(); k++; end while (data_dv !== 1'b1 && k < 10);
    exp_v = exp_q.pop_front();
    checks++;
    if (rgb_data_out !== exp_v) begin failures++; $display("FAIL rst_test_pix0 got=%h want=%h", rgb_data_out, exp_v); end
    read_en = 1'b0;
    repeat (3) tick();
    read_en = 1'b1;
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({data_dv, write_config, commit_ack, frame_done, busy} !== 5'b0 || rgb_data_out !== 24'd0) begin
      failures++; $display("FAIL midframe_rst_outputs strobes=%b rgb=%h want=00000/000000",
                           {data_dv, write_config, commit_ack, frame_done, busy}, rgb_data_out);
    end
    checks++;
    if (frame_cnt !== 16'd0 || num_leds_out !== 16'd10 || delay_out !== 16'd15000) begin
      failures++; $display("FAIL midframe_rst_regs cnt=%0d num=%0d delay=%0d want=0/10/15000", frame_cnt, num_leds_out, delay_out);
    end
    dv0 = mon_dv;
    tick();
    rst = 1'b0;
    bfront = 1'b0;
    exp_fcnt = 0;
    for (int i = 0; i < 12; i++) begin read_en = (i % 3) != 0; tick(); end
    read_en = 1'b0;
    checks++;
    if (mon_dv != dv0 || busy !== 1'b0) begin
      failures++; $display("FAIL post_rst_quiet dv=%0d busy=%b want=0/0", mon_dv - dv0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_cfg_frame();
    test_pixels_commit();
    test_hold();
    test_midframe();
    test_clamp_zero();
    test_rst_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
